// File: rtl/memory_access_stage_if.sv
// rtl/memory_access_stage_if.sv - data-memory bus between the MEM stage and the data memory
interface memory_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MIPS32 MEM stage: big-endian lane steering, bus handshake, MEM/WB register
module memory_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        me_mem_read,
  input  logic        me_mem_write,
  input  logic        me_mem_to_reg,
  input  logic        me_reg_write,
  input  logic [1:0]  me_mem_size,
  input  logic        me_mem_signed,
  input  logic [31:0] me_alu_result,
  input  logic [31:0] me_data2_reg,
  input  logic [4:0]  me_rt_rd,
  memory_access_stage_if.master dmem,
  output logic        me_stall,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_rt_rd,
  output logic        me_addr_error,
  output logic        me_bus_error
);
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [1:0]    offs;
  logic          op, aligned, misaligned_op, timeout_now, req;
  logic [3:0]    be;
  logic [31:0]   wdata, load_ext;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  assign offs = me_alu_result[1:0];
  assign op   = me_mem_read | me_mem_write;

  always_comb begin
    aligned = 1'b1;
    case (me_mem_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~offs[0];
      default: aligned = (offs == 2'b00);
    endcase
  end

  assign misaligned_op = op & ~aligned;
  assign req = ~reset & (((state == IDLE) & op & aligned) | (state == WAIT));
  assign timeout_now = (TIMEOUT_CYCLES != 0) && (state == WAIT) && !dmem.dmem_ready
                       && (count == CW'(TIMEOUT_CYCLES));
  assign me_stall = req & ~dmem.dmem_ready & ~timeout_now;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (req && !dmem.dmem_ready) begin
          state_nxt = WAIT;
          count_nxt = CW'(1);
        end
      end
      WAIT: begin
        if (dmem.dmem_ready || timeout_now) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // Byte k of a word lives in bits [31-8k -: 8] (big-endian).
  always_comb begin
    lane_b = dmem.dmem_rdata[31:24];
    case (offs)
      2'd0:    lane_b = dmem.dmem_rdata[31:24];
      2'd1:    lane_b = dmem.dmem_rdata[23:16];
      2'd2:    lane_b = dmem.dmem_rdata[15:8];
      default: lane_b = dmem.dmem_rdata[7:0];
    endcase
    lane_h = offs[1] ? dmem.dmem_rdata[15:0] : dmem.dmem_rdata[31:16];
  end

  always_comb begin
    be       = 4'b1111;
    wdata    = me_data2_reg;
    load_ext = dmem.dmem_rdata;
    case (me_mem_size)
      2'b00: begin
        be       = 4'b1000 >> offs;
        wdata    = {4{me_data2_reg[7:0]}};
        load_ext = {{24{me_mem_signed & lane_b[7]}}, lane_b};
      end
      2'b01: begin
        be       = offs[1] ? 4'b0011 : 4'b1100;
        wdata    = {2{me_data2_reg[15:0]}};
        load_ext = {{16{me_mem_signed & lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & me_mem_write;
  assign dmem.dmem_addr  = reset ? 32'h0 : {me_alu_result[31:2], 2'b00};
  assign dmem.dmem_be    = reset ? 4'h0 : be;
  assign dmem.dmem_wdata = reset ? 32'h0 : wdata;

  // Stalled and faulted cycles leave the MEM/WB register as a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_read_data  <= 32'h0;
      wb_alu_result <= 32'h0;
      wb_rt_rd      <= 5'h0;
      me_addr_error <= 1'b0;
      me_bus_error  <= 1'b0;
    end else begin
      wb_reg_write  <= me_reg_write & ~me_stall & ~misaligned_op & ~timeout_now;
      wb_mem_to_reg <= me_mem_to_reg;
      wb_read_data  <= load_ext;
      wb_alu_result <= me_alu_result;
      wb_rt_rd      <= me_rt_rd;
      me_addr_error <= misaligned_op & (state == IDLE);
      me_bus_error  <= timeout_now;
    end
  end
endmodule
